ov7670_tx: RTL and testbench
============================

Name: ov7670_tx

Overview:
- Synthetic OV7670 camera source for simulation and bring-up.
- Emits the sensor's parallel byte stream (vsync, href, px_data) in RGB565, two bytes per pixel, with programmable frame and line blanking.
- Drives the capture path from the sensor side, so the full capture-to-memory chain can be exercised without a real camera.
- Pixel payload comes from a frame memory read port, or from an internal colour-bar generator.

Parameters:
- AW, 15, width of the pixel memory read address.
- H_ACTIVE, 160, active pixels per line (each pixel is 2 bytes).
- V_ACTIVE, 120, active lines per frame.
- H_BLANK, 16, href-low cycles after each line's active bytes.
- VSYNC_LINES, 3, line periods with vsync high.
- V_BACK, 17, blank line periods after vsync.
- V_FRONT, 10, blank line periods after the last active line.

Ports:
- pclk  in  1  pixel clock; every output is launched on the posedge.
- rst  in  1  synchronous reset, active-low.
- enable  in  1  frame generation request; sampled only at frame start.
- pattern_sel  in  1  1 = colour bars, 0 = memory data; sampled at frame start.
- mem_rd_addr  out  AW  pixel address into the frame memory.
- mem_rd_en  out  1  read strobe; read data is valid exactly 1 cycle later.
- mem_rd_data  in  16  RGB565 pixel from memory.
- vsync  out  1  frame sync, active high.
- href  out  1  high during a line's active bytes.
- px_data  out  8  byte stream.
- frame_done  out  1  1-cycle pulse on the last cycle of V_FRONT.

Behaviour:
- Line period: LINE_LEN = 2*H_ACTIVE + H_BLANK cycles, identical for every line type.
- Reset (rst=0 at a posedge): state IDLE; all counters 0.
  - Outputs: vsync=0, href=0, px_data=0, mem_rd_addr=0, mem_rd_en=0, frame_done=0.
  - Takes effect at the next edge even mid-frame. No partial line is completed.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE -> VSYNC when enable=1. pattern_sel is latched on this transition.
  - VSYNC -> VBACK after VSYNC_LINES*LINE_LEN cycles. vsync=1 throughout VSYNC.
  - VBACK -> ACTIVE after V_BACK*LINE_LEN cycles.
  - ACTIVE: V_ACTIVE lines. In each line, href=1 for cycles 0..2*H_ACTIVE-1, then href=0 for H_BLANK cycles. ACTIVE -> VFRONT after the last line.
  - VFRONT -> VSYNC (back-to-back frame) if enable=1 on its last cycle, else -> IDLE. frame_done=1 on that last cycle in both cases.
  - Deasserting enable mid-frame has no effect; the frame completes.
- Byte order, per pixel:
  - Even byte (first): pixel[15:8] = R4..R0,G5..G3.
  - Odd byte (second): pixel[7:0] = G2..G0,B4..B0.
  - px_data is held at 0 whenever href=0.
- Memory read timing:
  - mem_rd_en pulses 1 cycle before each pixel's even byte, with mem_rd_addr = line*H_ACTIVE + x.
  - mem_rd_data is captured on the even-byte cycle into a 16-bit holding register.
  - The even byte is driven from mem_rd_data directly; the odd byte from the holding register.
  - First read of a line is issued on the last cycle of the preceding blank period, whether VBACK or H_BLANK.
  - Address increments linearly across the frame and resets to 0 at frame start.
  - Last address is H_ACTIVE*V_ACTIVE-1 (19199 with defaults); it never wraps inside a frame.
- Pattern mode:
  - x in 0..H_ACTIVE-1; bar = x*8/H_ACTIVE, computed by comparing x against 7 precomputed thresholds (no divider).
  - Colour from the BAR_COLOURS table.
  - mem_rd_en stays 0.
- Counter widths: byte counter ceil(log2(LINE_LEN)); line counter sized for the largest of VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT.

Decomposition:
- Package ov7670_pkg:
  - FSM state encoding.
  - RGB565 constant BAR_COLOURS[0..7] = FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Function for the byte split of a pixel.
- Sub-module ov7670_timing (natural split):
  - Owns the FSM, byte and line counters, vsync, href, frame_done.
  - Exports the pixel x, the active line index, and a pre-fetch strobe.
  - The top module adds the address generation, data mux and byte serializer.

Test Plan:
- Reset: rst=0 for 3 cycles mid-ACTIVE -> next edge all outputs 0, state IDLE; rst=1 with enable=0 -> vsync and href stay 0 for 1000 cycles.
- Timing (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, enable=1):
  - vsync high exactly 10 cycles.
  - href high 8 cycles, low 2 cycles, twice.
  - frame_done at cycle 49 after frame start (50-cycle frame).
- Memory path: memory word[a] = 16'hA500+a, default parameters -> first line bytes A5,00,A5,01,...
  - 19200 mem_rd_en pulses per frame.
  - Last address 19199.
  - Every read is exactly 1 cycle before its even byte.
- Colour bars: pattern_sel=1, H_ACTIVE=160 -> pixels 0..19 emit FF,FF; pixel 20 emits FF,E0; pixel 159 emits 00,00; mem_rd_en never asserted.
- Enable handling:
  - enable dropped mid-frame -> frame completes and frame_done pulses, then IDLE.
  - enable held high -> VSYNC begins on the cycle after frame_done (no gap).
  - pattern_sel toggled mid-frame is ignored until the next frame.
- Loopback: connect to the capture block in a shared bench -> memory holds 19200 RGB332 pixels matching the truncated RGB565 source, addresses 0..19199.

Source files
------------

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared state encoding, colour-bar table and byte split for the OV7670 source
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } ov_state_t;

  localparam logic [15:0] BAR_COLOURS [0:7] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  // First byte on the wire is R4..R0,G5..G3; second is G2..G0,B4..B0.
  function automatic logic [7:0] byte_of(input logic [15:0] pixel, input logic odd);
    return odd ? pixel[7:0] : pixel[15:8];
  endfunction

endpackage

// File: rtl/ov7670_tx_if.sv
// rtl/ov7670_tx_if.sv - sensor-side video outputs and frame memory read port
interface ov7670_tx_if #(parameter int AW = 15);
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_en;
  logic [15:0]   mem_rd_data;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic          frame_done;

  modport master (
    output mem_rd_addr, mem_rd_en, vsync, href, px_data, frame_done,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_addr, mem_rd_en, vsync, href, px_data, frame_done,
    output mem_rd_data
  );
endinterface

// File: rtl/ov7670_timing.sv
// rtl/ov7670_timing.sv - frame FSM, byte/line counters and registered sync strobes
module ov7670_timing
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int XW          = $clog2(H_ACTIVE + 1)
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          enable,
  input  logic          pattern_sel,
  output logic          vsync,
  output logic          href,
  output logic          frame_done,
  output logic          byte_odd,
  output logic          prefetch,
  output logic          pat_mode,
  output logic [XW-1:0] x
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int VM1  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int VM2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int VMAX = (VM1 > VM2) ? VM1 : VM2;
  localparam int BW   = $clog2(LINE_LEN);
  localparam int LW   = $clog2(VMAX + 1);

  localparam logic [BW-1:0] B_LAST     = BW'(LINE_LEN - 1);
  localparam logic [BW-1:0] B_HREF     = BW'(2 * H_ACTIVE);
  localparam logic [BW-1:0] B_PRE_LAST = BW'(2 * H_ACTIVE - 1);
  localparam logic [LW-1:0] L_VSYNC    = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] L_VBACK    = LW'(V_BACK - 1);
  localparam logic [LW-1:0] L_ACTIVE   = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] L_VFRONT   = LW'(V_FRONT - 1);

  ov_state_t     state, nxt_state;
  logic [BW-1:0] bcnt, nxt_b;
  logic [LW-1:0] lcnt, nxt_l;
  logic          nxt_pat;
  logic          line_end;

  always_comb begin
    nxt_state = state;
    nxt_b     = bcnt;
    nxt_l     = lcnt;
    nxt_pat   = pat_mode;
    line_end  = (bcnt == B_LAST);
    if (state == ST_IDLE) begin
      nxt_b = '0;
      nxt_l = '0;
      if (enable) begin
        nxt_state = ST_VSYNC;
        nxt_pat   = pattern_sel;
      end
    end else begin
      nxt_b = line_end ? '0 : bcnt + BW'(1);
      if (line_end) begin
        nxt_l = lcnt + LW'(1);
        case (state)
          ST_VSYNC:  if (lcnt == L_VSYNC)  begin nxt_state = ST_VBACK;  nxt_l = '0; end
          ST_VBACK:  if (lcnt == L_VBACK)  begin nxt_state = ST_ACTIVE; nxt_l = '0; end
          ST_ACTIVE: if (lcnt == L_ACTIVE) begin nxt_state = ST_VFRONT; nxt_l = '0; end
          ST_VFRONT: if (lcnt == L_VFRONT) begin
            nxt_l = '0;
            if (enable) begin
              nxt_state = ST_VSYNC;
              nxt_pat   = pattern_sel;
            end else begin
              nxt_state = ST_IDLE;
            end
          end
          default: nxt_state = ST_IDLE;
        endcase
      end
    end
  end

  // Outputs are registered from the next-cycle view so they line up with state/bcnt/lcnt.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      bcnt       <= '0;
      lcnt       <= '0;
      pat_mode   <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      frame_done <= 1'b0;
      byte_odd   <= 1'b0;
      prefetch   <= 1'b0;
      x          <= '0;
    end else begin
      state      <= nxt_state;
      bcnt       <= nxt_b;
      lcnt       <= nxt_l;
      pat_mode   <= nxt_pat;
      vsync      <= (nxt_state == ST_VSYNC);
      href       <= (nxt_state == ST_ACTIVE) && (nxt_b < B_HREF);
      byte_odd   <= nxt_b[0];
      x          <= XW'(nxt_b >> 1);
      frame_done <= (nxt_state == ST_VFRONT) && (nxt_b == B_LAST) && (nxt_l == L_VFRONT);
      prefetch   <= ((nxt_state == ST_ACTIVE) && nxt_b[0] && (nxt_b < B_PRE_LAST))
                 || ((nxt_state == ST_ACTIVE) && (nxt_b == B_LAST) && (nxt_l != L_ACTIVE))
                 || ((nxt_state == ST_VBACK) && (nxt_b == B_LAST) && (nxt_l == L_VBACK));
    end
  end

endmodule

// File: rtl/ov7670_tx.sv
// rtl/ov7670_tx.sv - synthetic OV7670 RGB565 byte-stream source fed from memory or colour bars
module ov7670_tx
  import ov7670_pkg::*;
#(
  parameter int AW          = 15,
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pattern_sel,
  ov7670_tx_if.master bus
);

  localparam int XW = $clog2(H_ACTIVE + 1);

  logic          vsync, href, frame_done, byte_odd, prefetch, pat_mode;
  logic [XW-1:0] x;
  logic [AW-1:0] addr_cnt;
  logic [15:0]   hold;
  logic [15:0]   pix;
  logic          rd;

  ov7670_timing #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .H_BLANK    (H_BLANK),
    .VSYNC_LINES(VSYNC_LINES),
    .V_BACK     (V_BACK),
    .V_FRONT    (V_FRONT),
    .XW         (XW)
  ) u_timing (
    .pclk       (pclk),
    .rst        (rst),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .vsync      (vsync),
    .href       (href),
    .frame_done (frame_done),
    .byte_odd   (byte_odd),
    .prefetch   (prefetch),
    .pat_mode   (pat_mode),
    .x          (x)
  );

  // bar = x*8/H_ACTIVE, found by counting the seven thresholds ceil(k*H_ACTIVE/8) that x reaches.
  function automatic logic [2:0] bar_of(input logic [XW-1:0] xv);
    logic [2:0] b;
    b = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(xv) >= (k * H_ACTIVE + 7) / 8) b = b + 3'd1;
    end
    return b;
  endfunction

  assign rd  = prefetch & ~pat_mode;
  assign pix = pat_mode ? BAR_COLOURS[bar_of(x)] : bus.mem_rd_data;

  always_ff @(posedge pclk) begin
    if (!rst) begin
      addr_cnt <= '0;
      hold     <= '0;
    end else begin
      if (frame_done)  addr_cnt <= '0;
      else if (rd)     addr_cnt <= addr_cnt + AW'(1);
      if (href && !byte_odd) hold <= pix;
    end
  end

  assign bus.mem_rd_addr = addr_cnt;
  assign bus.mem_rd_en   = rd;
  assign bus.vsync       = vsync;
  assign bus.href        = href;
  assign bus.frame_done  = frame_done;
  assign bus.px_data     = href ? byte_of(byte_odd ? hold : pix, byte_odd) : 8'h00;

endmodule

// File: tb/tb_ov7670_tx.sv
// tb/tb_ov7670_tx.sv - directed table-driven checks of the OV7670 source at three geometries
module tb_ov7670_tx;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic rst_s, en_s, ps_s;
  logic rst_p, en_p, ps_p;
  logic rst_m, en_m, ps_m;

  ov7670_tx_if #(.AW(15)) if_s ();
  ov7670_tx_if #(.AW(15)) if_p ();
  ov7670_tx_if #(.AW(15)) if_m ();

  ov7670_tx #(.AW(15), .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2),
              .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1))
    dut_s (.pclk(pclk), .rst(rst_s), .enable(en_s), .pattern_sel(ps_s), .bus(if_s));

  ov7670_tx #(.AW(15), .H_ACTIVE(160), .V_ACTIVE(2), .H_BLANK(16),
              .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1))
    dut_p (.pclk(pclk), .rst(rst_p), .enable(en_p), .pattern_sel(ps_p), .bus(if_p));

  ov7670_tx #(.AW(15))
    dut_m (.pclk(pclk), .rst(rst_m), .enable(en_m), .pattern_sel(ps_m), .bus(if_m));

  // Frame memories: word[a] = A500 + a, valid the cycle after the strobe, junk otherwise.
  always @(posedge pclk) begin
    if_s.mem_rd_data <= if_s.mem_rd_en ? 16'hA500 + {1'b0, if_s.mem_rd_addr} : 16'hDEAD;
    if_m.mem_rd_data <= if_m.mem_rd_en ? 16'hA500 + {1'b0, if_m.mem_rd_addr} : 16'hDEAD;
  end
  assign if_p.mem_rd_data = 16'h1234;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the caller at the negedge of the first vsync-high cycle (cycle 0).
  task automatic wait_start(input int which, output logic ok);
    logic v;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      v = (which == 0) ? if_s.vsync : (which == 1) ? if_p.vsync : if_m.vsync;
      if (v) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    int cyc; int vs; int hr; int fd; int en; int px; int addr;
  } vec_t;

  typedef struct {
    int idx; int px;
  } byte_vec_t;

  vec_t      vecs[$];
  byte_vec_t pvecs[$];
  logic [7:0] pbytes [0:639];

  initial begin
    logic ok;
    int nv, nh, bad, nb, nrd, fd_seen;
    int pix, reads, last_addr, derr, terr, prev_en, prev_addr, odd_t;
    logic [15:0] w;

    // cyc, vsync, href, frame_done, mem_rd_en, px_data, mem_rd_addr
    vecs.push_back('{0,   1, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{9,   1, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{10,  0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{19,  0, 0, 0, 1, 8'h00, 0});
    vecs.push_back('{20,  0, 1, 0, 0, 8'hA5, 1});
    vecs.push_back('{21,  0, 1, 0, 1, 8'h00, 1});
    vecs.push_back('{23,  0, 1, 0, 1, 8'h01, 2});
    vecs.push_back('{27,  0, 1, 0, 0, 8'h03, 4});
    vecs.push_back('{28,  0, 0, 0, 0, 8'h00, 4});
    vecs.push_back('{29,  0, 0, 0, 1, 8'h00, 4});
    vecs.push_back('{30,  0, 1, 0, 0, 8'hA5, 5});
    vecs.push_back('{31,  0, 1, 0, 1, 8'h04, 5});
    vecs.push_back('{37,  0, 1, 0, 0, 8'h07, 8});
    vecs.push_back('{48,  0, 0, 0, 0, 8'h00, 8});
    vecs.push_back('{49,  0, 0, 1, 0, 8'h00, 8});
    vecs.push_back('{50,  1, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{69,  0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{70,  0, 1, 0, 0, 8'hFF, 0});
    vecs.push_back('{71,  0, 1, 0, 0, 8'hFF, 0});
    vecs.push_back('{72,  0, 1, 0, 0, 8'h07, 0});
    vecs.push_back('{73,  0, 1, 0, 0, 8'hFF, 0});
    vecs.push_back('{74,  0, 1, 0, 0, 8'hF8, 0});
    vecs.push_back('{75,  0, 1, 0, 0, 8'h1F, 0});
    vecs.push_back('{76,  0, 1, 0, 0, 8'h00, 0});
    vecs.push_back('{77,  0, 1, 0, 0, 8'h1F, 0});
    vecs.push_back('{99,  0, 0, 1, 0, 8'h00, 0});
    vecs.push_back('{100, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{120, 0, 0, 0, 0, 8'h00, 0});

    // byte index within the two-line pattern capture, expected byte
    pvecs.push_back('{0,   8'hFF}); pvecs.push_back('{1,   8'hFF});
    pvecs.push_back('{38,  8'hFF}); pvecs.push_back('{39,  8'hFF});
    pvecs.push_back('{40,  8'hFF}); pvecs.push_back('{41,  8'hE0});
    pvecs.push_back('{80,  8'h07}); pvecs.push_back('{81,  8'hFF});
    pvecs.push_back('{318, 8'h00}); pvecs.push_back('{319, 8'h00});
    pvecs.push_back('{360, 8'hFF}); pvecs.push_back('{361, 8'hE0});

    rst_s = 0; en_s = 0; ps_s = 0;
    rst_p = 0; en_p = 0; ps_p = 1;
    rst_m = 0; en_m = 0; ps_m = 0;
    repeat (3) @(negedge pclk);
    check("rst_vsync", if_s.vsync, 0);
    check("rst_href", if_s.href, 0);
    check("rst_px", if_s.px_data, 0);
    check("rst_addr", if_s.mem_rd_addr, 0);
    check("rst_rden", if_s.mem_rd_en, 0);
    check("rst_fd", if_s.frame_done, 0);
    rst_s = 1; rst_p = 1; rst_m = 1;

    // Two back-to-back frames: memory then (late-latched) colour bars, then enable drops.
    en_s = 1;
    wait_start(0, ok);
    check("s_frame_start", ok, 1);
    nv = 0; nh = 0;
    for (int c = 0; c <= 120; c++) begin
      if (c > 0) @(negedge pclk);
      foreach (vecs[i]) begin
        if (vecs[i].cyc == c) begin
          check($sformatf("c%0d_vsync", c), if_s.vsync, vecs[i].vs);
          check($sformatf("c%0d_href", c), if_s.href, vecs[i].hr);
          check($sformatf("c%0d_fd", c), if_s.frame_done, vecs[i].fd);
          check($sformatf("c%0d_rden", c), if_s.mem_rd_en, vecs[i].en);
          check($sformatf("c%0d_px", c), if_s.px_data, vecs[i].px);
          check($sformatf("c%0d_addr", c), if_s.mem_rd_addr, vecs[i].addr);
        end
      end
      if (c < 50) begin nv += int'(if_s.vsync); nh += int'(if_s.href); end
      if (c == 25) ps_s = 1;
      if (c == 60) en_s = 0;
    end
    check("s_vsync_cycles", nv, 10);
    check("s_href_cycles", nh, 16);

    // Reset mid-ACTIVE, then idle with enable low.
    ps_s = 0; en_s = 1;
    wait_start(0, ok);
    check("s_restart", ok, 1);
    repeat (25) @(negedge pclk);
    check("pre_rst_href", if_s.href, 1);
    rst_s = 0;
    @(negedge pclk);
    check("mid_rst_vsync", if_s.vsync, 0);
    check("mid_rst_href", if_s.href, 0);
    check("mid_rst_px", if_s.px_data, 0);
    check("mid_rst_addr", if_s.mem_rd_addr, 0);
    check("mid_rst_rden", if_s.mem_rd_en, 0);
    check("mid_rst_fd", if_s.frame_done, 0);
    repeat (2) @(negedge pclk);
    rst_s = 1; en_s = 0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge pclk);
      if (if_s.vsync || if_s.href) bad++;
    end
    check("idle_quiet", bad, 0);
    en_s = 1;
    wait_start(0, ok);
    check("post_rst_start", ok, 1);
    en_s = 0;
    repeat (19) @(negedge pclk);
    check("post_rst_rden", if_s.mem_rd_en, 1);
    check("post_rst_addr", if_s.mem_rd_addr, 0);

    // Colour bars at H_ACTIVE=160.
    en_p = 1;
    wait_start(1, ok);
    check("p_frame_start", ok, 1);
    en_p = 0;
    nb = 0; nrd = 0; fd_seen = 0;
    for (int c = 0; c < 1800 && !fd_seen; c++) begin
      if (c > 0) @(negedge pclk);
      if (if_p.mem_rd_en) nrd++;
      if (if_p.href) begin
        if (nb < 640) pbytes[nb] = if_p.px_data;
        nb++;
      end
      if (if_p.frame_done) fd_seen = 1;
      if (c == 700) ps_p = 0;
    end
    check("p_frame_done", fd_seen, 1);
    check("p_rden_count", nrd, 0);
    check("p_byte_count", nb, 640);
    foreach (pvecs[i]) check($sformatf("p_byte%0d", pvecs[i].idx), pbytes[pvecs[i].idx], pvecs[i].px);

    // Full default frame from memory.
    en_m = 1;
    wait_start(2, ok);
    check("m_frame_start", ok, 1);
    en_m = 0;
    pix = 0; reads = 0; last_addr = -1; derr = 0; terr = 0;
    prev_en = 0; prev_addr = 0; odd_t = 0; fd_seen = 0; nb = 0;
    w = 16'h0;
    for (int c = 0; c < 52000 && !fd_seen; c++) begin
      if (c > 0) @(negedge pclk);
      if (prev_en != 0 && !(if_m.href && odd_t == 0)) terr++;
      if (if_m.href) begin
        if (odd_t == 0) begin
          w = 16'hA500 + 16'(pix);
          if (if_m.px_data !== w[15:8]) derr++;
          if (prev_en == 0 || prev_addr != pix) terr++;
        end else begin
          if (if_m.px_data !== w[7:0]) derr++;
          pix++;
        end
        odd_t = 1 - odd_t;
        nb++;
      end else if (if_m.px_data !== 8'h00) begin
        derr++;
      end
      if (if_m.mem_rd_en) begin reads++; last_addr = int'(if_m.mem_rd_addr); end
      prev_en = int'(if_m.mem_rd_en);
      prev_addr = int'(if_m.mem_rd_addr);
      if (if_m.frame_done) fd_seen = 1;
    end
    check("m_frame_done", fd_seen, 1);
    check("m_reads", reads, 19200);
    check("m_last_addr", last_addr, 19199);
    check("m_bytes", nb, 38400);
    check("m_data_errors", derr, 0);
    check("m_read_timing_errors", terr, 0);
    @(negedge pclk);
    check("m_idle_after", if_m.vsync, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
